instr_encoder: RTL and testbench

Sequential instruction encoder and imem writer: the encode-side counterpart of the CPU control decoder. It accepts decoded instruction fields over a valid/ready handshake, checks that the opcode matches the declared format, and packs each instruction into the 32-bit R/I/JI/JII word layout the decoder consumes. Encoded words are buffered in a small FIFO and written to consecutive instruction-memory addresses, for use by program loaders, self-test generators and testbenches.

---
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit R/I/JI/JII words and streams them
// through a small FIFO into consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [4:0]        aluop,
  input  logic [16:0]       imm,
  input  logic [26:0]       target,
  input  logic              stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   words_written,
  output logic              err,
  output logic              ovf,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_err;
  logic              r_ovf;

  logic        w_full;
  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign w_full    = (r_count == LP_DEPTH);
  assign in_ready  = !w_full;
  assign busy      = (r_count != '0);
  assign imem_we   = busy && !stall;
  assign imem_addr = r_addr;
  assign imem_data = r_mem[r_rd_ptr];
  assign words_written = r_words;
  assign err = r_err;
  assign ovf = r_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal && !clear;
  assign w_pop    = imem_we && !clear;

  always_comb begin
    w_legal = 1'b0;
    w_word  = '0;
    case (fmt)
      2'd0: begin
        w_legal = (opcode == 5'b00000);
        w_word  = {opcode, rd, rs, rt, shamt, aluop, 2'b00};
      end
      2'd1: begin
        w_legal = (opcode == 5'b00101) || (opcode == 5'b00111) || (opcode == 5'b01000) ||
                  (opcode == 5'b00010) || (opcode == 5'b00110);
        w_word  = {opcode, rd, rs, imm};
      end
      2'd2: begin
        w_legal = (opcode == 5'b00001) || (opcode == 5'b00011);
        w_word  = {opcode, target};
      end
      default: begin
        w_legal = (opcode == 5'b00100);
        w_word  = {opcode, rd, 22'b0};
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= LP_BASE;
      r_words  <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= LP_BASE;
      r_words  <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + 1'b1;
        if (r_addr == '1) r_ovf <= 1'b1;
        if (r_words != '1) r_words <= r_words + 1'b1;
      end
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue-based reference model checked every
// cycle against two instances (12-bit and 2-bit address), plus literal pins.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] fmt = '0;
  logic [4:0] opcode = '0, rd = '0, rs = '0, rt = '0, shamt = '0, aluop = '0;
  logic [16:0] imm = '0;
  logic [26:0] target = '0;
  logic stall = 1'b0;

  logic        in_ready, imem_we, err, ovf, busy;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [12:0] words_written;

  logic        in_ready2, imem_we2, err2, ovf2, busy2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic [2:0]  words_written2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          mtotal = 0;
  bit          merr = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(12), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .aluop(aluop),
    .imm(imm), .target(target), .stall(stall), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .words_written(words_written), .err(err), .ovf(ovf), .busy(busy)
  );

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .aluop(aluop),
    .imm(imm), .target(target), .stall(stall), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .words_written(words_written2), .err(err2), .ovf(ovf2), .busy(busy2)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word and legality computed from field positions by arithmetic.
  function automatic logic [32:0] model_enc(input int f, input int op, input int a, input int b,
                                            input int c, input int s, input int al,
                                            input int im, input int tg);
    longint unsigned w;
    bit legal;
    w = longint'(op) * 134217728;  // opcode occupies the top five bits
    case (f)
      0: begin
        legal = (op == 0);
        w += longint'(a) * 4194304 + longint'(b) * 131072 + longint'(c) * 4096 +
             longint'(s) * 128 + longint'(al) * 4;
      end
      1: begin
        legal = (op == 5) || (op == 7) || (op == 8) || (op == 2) || (op == 6);
        w += longint'(a) * 4194304 + longint'(b) * 131072 + longint'(im);
      end
      2: begin
        legal = (op == 1) || (op == 3);
        w += longint'(tg);
      end
      default: begin
        legal = (op == 4);
        w += longint'(a) * 4194304;
      end
    endcase
    return {legal, w[31:0]};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete(); mtotal = 0; merr = 0;
    end else if (clear) begin
      mq.delete(); mtotal = 0; merr = 0;
    end else begin
      int  pre;
      bit  acc, wr;
      logic [32:0] e;
      pre = mq.size();
      wr  = (pre > 0) && !stall;
      acc = in_valid && (pre < DEPTH);
      e = model_enc(int'(fmt), int'(opcode), int'(rd), int'(rs), int'(rt), int'(shamt),
                    int'(aluop), int'(imm), int'(target));
      if (wr) begin
        void'(mq.pop_front());
        mtotal++;
      end
      if (acc) begin
        if (e[32]) mq.push_back(e[31:0]);
        else merr = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      bit exp_busy, exp_we;
      exp_busy = (mq.size() > 0);
      exp_we   = exp_busy && !stall && !reset;
      check("in_ready", in_ready, mq.size() < DEPTH);
      check("busy", busy, exp_busy);
      check("imem_we", imem_we, exp_we);
      check("err", err, merr);
      check("words_written", words_written, (mtotal > 8191) ? 8191 : mtotal);
      check("ovf", ovf, mtotal >= 4096);
      check("imem_addr", imem_addr, mtotal % 4096);
      if (exp_we && imem_we) check("imem_data", imem_data, mq[0]);
      check("in_ready_a2", in_ready2, mq.size() < DEPTH);
      check("imem_we_a2", imem_we2, exp_we);
      check("words_written_a2", words_written2, (mtotal > 7) ? 7 : mtotal);
      check("ovf_a2", ovf2, mtotal >= 4);
      check("imem_addr_a2", imem_addr2, mtotal % 4);
      if (exp_we && imem_we2) check("imem_data_a2", imem_data2, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [1:0] f, input logic [4:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
                      input logic [4:0] al, input logic [16:0] im, input logic [26:0] tg);
    int waits = 0;
    fmt = f; opcode = op; rd = a; rs = b; rt = c; shamt = s; aluop = al; imm = im; target = tg;
    in_valid = 1'b1;
    while (!in_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (waits >= 20) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 1); check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0); check("rst_data", imem_data, 0);
    check("rst_ww", words_written, 0); check("rst_busy", busy, 0);
    reset = 1'b0;
    chk_en = 1;
    tick();

    // Single R bundle: rd=3 rs=1 rt=2 -> 0x00C00000 + 0x00020000 + 0x00002000
    send(2'd0, 5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, '0, '0);
    check("r_we", imem_we, 1); check("r_addr", imem_addr, 0);
    check("r_data", imem_data, 32'h00C22000);
    tick();
    check("r_ww", words_written, 1); check("r_busy", busy, 0);

    // I / JI / JII on consecutive cycles
    do_clear();
    check("clr_addr", imem_addr, 0);
    send(2'd1, 5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, '0);
    check("i_data", imem_data, 32'h2841FFFF); check("i_addr", imem_addr, 0);
    send(2'd2, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, '0, 27'h0000040);
    check("ji_data", imem_data, 32'h18000040); check("ji_addr", imem_addr, 1);
    send(2'd3, 5'b00100, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, '0, '0);
    check("jii_data", imem_data, 32'h27C00000); check("jii_addr", imem_addr, 2);
    tick();

    // Stall with six bundles
    do_clear();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(2'd1, 5'b00111, 5'(i), 5'd2, 5'd0, 5'd0, 5'd0, 17'(i * 3), '0);
    check("stall_ready", in_ready, 0); check("stall_we", imem_we, 0);
    stall = 1'b0;
    send(2'd2, 5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, '0, 27'h5A5A5A5);
    send(2'd0, 5'd0, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, '0, '0);
    repeat (6) tick();
    check("stall_ww", words_written, 6); check("stall_addr", imem_addr, 6);

    // Illegal bundle leaves no gap
    send(2'd0, 5'b00101, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, '0, '0);
    check("ill_err", err, 1); check("ill_busy", busy, 0);
    send(2'd1, 5'b01000, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 17'h00123, '0);
    check("ill_next_addr", imem_addr, 6);
    tick();
    check("ill_err_sticky", err, 1);
    do_clear();
    check("clr_err", err, 0); check("clr_addr2", imem_addr, 0);

    // Address wrap on the 2-bit instance and words_written saturation
    for (int i = 0; i < 5; i++) send(2'd3, 5'b00100, 5'(i + 1), 5'd0, 5'd0, 5'd0, 5'd0, '0, '0);
    repeat (3) tick();
    check("wrap_ww", words_written2, 5); check("wrap_ovf", ovf2, 1);
    check("wrap_addr", imem_addr2, 1); check("wide_ovf", ovf, 0); check("wide_addr", imem_addr, 5);
    for (int i = 0; i < 3; i++) send(2'd2, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, '0, 27'(i));
    repeat (3) tick();
    check("sat_ww", words_written2, 7); check("wide_ww8", words_written, 8);

    // Reset mid-burst
    do_clear();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) send(2'd1, 5'b00010, 5'd9, 5'(i), 5'd0, 5'd0, 5'd0, 17'h0BEEF, '0);
    #3 reset = 1'b1;
    #1;
    check("mrst_we", imem_we, 0); check("mrst_busy", busy, 0);
    check("mrst_ww", words_written, 0); check("mrst_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    stall = 1'b0;
    send(2'd2, 5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, '0, 27'h7FFFFFF);
    check("post_rst_addr", imem_addr, 0); check("post_rst_we", imem_we, 1);
    check("post_rst_data", imem_data, 32'h0FFFFFFF);
    repeat (3) tick();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
